// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus arbiter and the address decoder.
// States, access-size encodings, region boundaries and the round-robin pick helper.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_t;

   typedef struct packed {
      logic rom;
      logic ram;
      logic peri;
   } sel_t;

   localparam logic [31:0] ROM_TOP_DEF   = 32'h0000_0FFF;
   localparam logic [31:0] PERI_BASE_DEF = 32'hFFFF_F000;

   // Winner index for a non-zero request vector; on a tie the master that was
   // not granted last wins.
   function automatic logic rr_winner(input logic [1:0] req, input logic last);
      if (req == 2'b11) begin
         return ~last;
      end
      return req[1];
   endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Address to one-hot {rom, ram, peri} chip select; purely combinational.
// Latency: none. Backpressure: none.
module mem_addr_decode
   import mem_bus_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter logic [31:0] ROM_TOP   = ROM_TOP_DEF,
   parameter logic [31:0] PERI_BASE = PERI_BASE_DEF
) (
   input  logic [ADDR_W-1:0] addr,
   output sel_t              sel
);

   localparam logic [ADDR_W-1:0] ROM_LAST  = ADDR_W'(ROM_TOP);
   localparam logic [ADDR_W-1:0] PERI_LOW  = ADDR_W'(PERI_BASE);

   // ROM takes priority so an overlapping configuration still yields one-hot.
   always_comb begin
      sel = '0;
      if (addr <= ROM_LAST) begin
         sel.rom = 1'b1;
      end else if (addr >= PERI_LOW) begin
         sel.peri = 1'b1;
      end else begin
         sel.ram = 1'b1;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory bus with address decode (optional ARB_LOCK_EN bus lock).
// Latency: req to ack pulse is 3 + WAIT_CYCLES edges; ROM writes complete in 3 edges with err_o.
// Backpressure: requests wait in IDLE until granted; req_i must be held until ack_o.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int          ADDR_W      = 32,
   parameter int          DATA_W      = 64,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] ROM_TOP     = ROM_TOP_DEF,
   parameter logic [31:0] PERI_BASE   = PERI_BASE_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        req_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   input  logic [1:0]        we_i,
   input  logic [1:0]        size0_i,
   input  logic [1:0]        size1_i,
   input  logic [1:0]        lock_i,
   output logic [1:0]        gnt_o,
   output logic [1:0]        ack_o,
   output logic              err_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_out,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic              mem_read,
   output logic              mem_write,
   output logic [1:0]        mem_size,
   output logic              rom_select,
   output logic              ram_select,
   output logic              peri_select
);

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t            state_q, state_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        ack_q, ack_d;
   logic              err_q, err_d;
   logic              err_cond_q, err_cond_d;
   logic              ptr_q, ptr_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              we_q, we_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   size_t             size_q, size_d;
   sel_t              sel_q, sel_d;

   logic              load;
   logic              lat_idx;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_we;
   size_t             lat_size;
   sel_t              lat_sel;

   // In IDLE the arbitration winner is loaded; otherwise the current owner reloads.
   assign lat_idx   = (state_q == IDLE) ? rr_winner(req_i, ptr_q) : gnt_q[1];
   assign lat_addr  = lat_idx ? addr1_i  : addr0_i;
   assign lat_wdata = lat_idx ? wdata1_i : wdata0_i;
   assign lat_we    = we_i[lat_idx];
   assign lat_size  = size_t'(lat_idx ? size1_i : size0_i);

   mem_addr_decode #(
      .ADDR_W    (ADDR_W),
      .ROM_TOP   (ROM_TOP),
      .PERI_BASE (PERI_BASE)
   ) u_addr_decode (
      .addr (lat_addr),
      .sel  (lat_sel)
   );

`ifndef ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = ^lock_i;
`endif

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      ack_d      = 2'b00;
      err_d      = 1'b0;
      err_cond_d = err_cond_q;
      ptr_d      = ptr_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      size_d     = size_q;
      sel_d      = sel_q;
      load       = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req_i) begin
               load    = 1'b1;
               gnt_d   = lat_idx ? 2'b10 : 2'b01;
               ptr_d   = lat_idx;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (sel_q.rom && we_q) begin
               err_cond_d = 1'b1;
               state_d    = DONE;
            end else begin
               err_cond_d = 1'b0;
               rd_d       = ~we_q;
               wr_d       = we_q;
               cnt_d      = WAIT_LD;
               state_d    = (WAIT_LD == 4'd0) ? DONE : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = DONE;
            end
         end
         DONE: begin
            ack_d   = gnt_q;
            err_d   = err_cond_q;
            if (!we_q) begin
               rdata_d = mem_data_in;
            end
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            sel_d   = '0;
            gnt_d   = 2'b00;
            state_d = IDLE;
`ifdef ARB_LOCK_EN
            // Locked owner chains straight into its next access; pointer untouched.
            if (lock_i[lat_idx] && req_i[lat_idx]) begin
               load    = 1'b1;
               gnt_d   = gnt_q;
               state_d = ACCESS;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         addr_d  = lat_addr;
         wdata_d = lat_wdata;
         we_d    = lat_we;
         size_d  = lat_size;
         sel_d   = lat_sel;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         gnt_q      <= 2'b00;
         ack_q      <= 2'b00;
         err_q      <= 1'b0;
         err_cond_q <= 1'b0;
         ptr_q      <= 1'b1;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         cnt_q      <= 4'd0;
         rdata_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         size_q     <= SZ_B;
         sel_q      <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         err_cond_q <= err_cond_d;
         ptr_q      <= ptr_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         size_q     <= size_d;
         sel_q      <= sel_d;
      end
   end

   assign gnt_o        = gnt_q;
   assign ack_o        = ack_q;
   assign err_o        = err_q;
   assign rdata_o      = rdata_q;
   assign mem_address  = addr_q;
   assign mem_data_out = wdata_q;
   assign mem_read     = rd_q;
   assign mem_write    = wr_q;
   assign mem_size     = size_q;
   assign rom_select   = sel_q.rom;
   assign ram_select   = sel_q.ram;
   assign peri_select  = sel_q.peri;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed and random accesses against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int WC = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic [1:0]    req_i, we_i, lock_i, size0_i, size1_i;
   logic [AW-1:0] addr0_i, addr1_i;
   logic [DW-1:0] wdata0_i, wdata1_i, mem_data_in;
   logic [1:0]    gnt_o, ack_o, mem_size;
   logic          err_o, mem_read, mem_write, rom_select, ram_select, peri_select;
   logic [DW-1:0] rdata_o, mem_data_out;
   logic [AW-1:0] mem_address;

   always #5 clock = ~clock;

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
      .clock(clock), .reset(reset), .req_i(req_i),
      .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
      .we_i(we_i), .size0_i(size0_i), .size1_i(size1_i), .lock_i(lock_i),
      .gnt_o(gnt_o), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
      .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
      .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
      .rom_select(rom_select), .ram_select(ram_select), .peri_select(peri_select)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic        exp_ptr;
   logic [63:0] exp_rdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // {rom, ram, peri} from the memory map
   function automatic logic [2:0] exp_decode(input logic [31:0] a);
      if (a <= 32'h0000_0FFF) return 3'b100;
      if (a >= 32'hFFFF_F000) return 3'b001;
      return 3'b010;
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 2))
         0:       return 32'($urandom_range(0, 32'h0FFF));
         1:       return 32'($urandom_range(32'h1000, 32'hFFFF_EFFF));
         default: return 32'hFFFF_F000 | 32'($urandom_range(0, 32'h0FFF));
      endcase
   endfunction

   task automatic rand_inputs();
      addr0_i     = rand_addr();
      addr1_i     = rand_addr();
      wdata0_i    = {$urandom, $urandom};
      wdata1_i    = {$urandom, $urandom};
      we_i        = 2'($urandom);
      size0_i     = 2'($urandom);
      size1_i     = 2'($urandom);
      mem_data_in = {$urandom, $urandom};
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_ctl"}, {gnt_o, ack_o, err_o, mem_read, mem_write,
                            rom_select, ram_select, peri_select}, 64'd0);
      check({pfx, "_rdata"}, rdata_o, 64'd0);
      check({pfx, "_addr"}, mem_address, 64'd0);
      check({pfx, "_wdata"}, mem_data_out, 64'd0);
      check({pfx, "_size"}, mem_size, 64'd0);
   endtask

   // One access from request to ack, with the expected outcome derived from the rules.
   task automatic txn(input logic [1:0] req, input bit drop_early);
      logic        w, we, romw;
      logic [31:0] a;
      logic [63:0] wd;
      logic [1:0]  sz;
      logic [2:0]  es;
      int          edges, strobes, bad_bus, bad_gnt, exp_lat;
      bit          got;
      w       = (req == 2'b11) ? ~exp_ptr : req[1];
      a       = w ? addr1_i : addr0_i;
      wd      = w ? wdata1_i : wdata0_i;
      sz      = w ? size1_i : size0_i;
      we      = we_i[w];
      es      = exp_decode(a);
      romw    = es[2] & we;
      exp_lat = romw ? 3 : 3 + WC;
      req_i   = req;
      edges = 0; strobes = 0; bad_bus = 0; bad_gnt = 0; got = 0;
      while (!got && edges < 40) begin
         @(posedge clock); #1;
         edges++;
         if (drop_early && edges == 2) req_i = 2'b00;
         if (ack_o !== 2'b00) begin
            got = 1;
            check("ack_vec", ack_o, 64'(2'b01 << w));
            check("ack_latency", edges, exp_lat);
            check("err", err_o, romw);
            if (!we) exp_rdata = mem_data_in;
            check("rdata", rdata_o, exp_rdata);
            check("idle_after_ack", {gnt_o, mem_read, mem_write,
                                     rom_select, ram_select, peri_select}, 64'd0);
         end else begin
            if (gnt_o !== (2'b01 << w)) bad_gnt++;
            if ({rom_select, ram_select, peri_select} !== es || mem_address !== a ||
                mem_data_out !== wd || mem_size !== sz) bad_bus++;
            if (mem_read || mem_write) begin
               strobes++;
               if (mem_read !== !we || mem_write !== we) bad_bus++;
            end
         end
      end
      req_i   = 2'b00;
      exp_ptr = w;
      check("ack_seen", got, 1);
      check("strobe_cycles", strobes, romw ? 0 : WC + 1);
      check("gnt_hold", bad_gnt, 0);
      check("bus_values", bad_bus, 0);
   endtask

   logic [31:0] bnd [4];
   int          acks, edges, last;

   initial begin
      reset = 1'b0; req_i = 2'b00; we_i = 2'b00; lock_i = 2'b00;
      addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
      size0_i = 2'b00; size1_i = 2'b00; mem_data_in = '0;
      exp_ptr = 1'b1; exp_rdata = '0;
      repeat (3) @(posedge clock);
      #1;
      check_reset("reset");
      reset = 1'b1;

      // Single read from ROM
      addr0_i = 32'h100; we_i = 2'b00; size0_i = 2'd2; wdata0_i = 64'h1111;
      mem_data_in = 64'hDEAD;
      txn(2'b01, 0);

      // ROM write by master 1: no strobe, error, rdata unchanged
      addr1_i = 32'h10; we_i = 2'b10; size1_i = 2'd3; wdata1_i = 64'hBEEF;
      mem_data_in = 64'h1234;
      txn(2'b10, 0);

      // Peripheral byte write
      addr0_i = 32'hFFFF_F004; wdata0_i = 64'h5A; size0_i = 2'd0; we_i = 2'b01;
      txn(2'b01, 0);

      // Region boundaries
      bnd = '{32'h0000_0FFF, 32'h0000_1000, 32'hFFFF_EFFF, 32'hFFFF_F000};
      for (int i = 0; i < 4; i++) begin
         rand_inputs();
         addr0_i = bnd[i];
         we_i    = {1'b0, i[0]};
         txn(2'b01, 0);
      end
      rand_inputs();
      addr1_i = 32'h0000_0FFF; we_i = 2'b10;
      txn(2'b10, 0);

      // Held conflict alternates; lock is ignored unless the feature is built in
`ifdef ARB_LOCK_EN
      lock_i = 2'b00;
`else
      lock_i = 2'b11;
`endif
      rand_inputs();
      for (int i = 0; i < 4; i++) txn(2'b11, 0);
      lock_i = 2'b00;

      // Random traffic
      for (int i = 0; i < 30; i++) begin
         rand_inputs();
         txn(2'($urandom_range(1, 3)), bit'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      end

      // Reset in the second WAIT cycle aborts the access and restores the pointer
      addr0_i = 32'h0000_2000; we_i = 2'b00; size0_i = 2'd3;
      wdata0_i = 64'hCAFE_F00D; mem_data_in = 64'h7777;
      req_i = 2'b01;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         check("abort_no_ack", ack_o, 64'd0);
      end
      reset = 1'b0;
      @(posedge clock); #1;
      check_reset("midwait");
      reset = 1'b1;
      exp_ptr = 1'b1; exp_rdata = '0;
      rand_inputs();
      txn(2'b11, 0);

`ifdef ARB_LOCK_EN
      rand_inputs();
      txn(2'b10, 0);
      rand_inputs();
      we_i = 2'b00;
      lock_i = 2'b01; req_i = 2'b11;
      acks = 0; edges = 0; last = 0;
      while (acks < 3 && edges < 100) begin
         @(posedge clock); #1;
         edges++;
         if (ack_o !== 2'b00) begin
            acks++;
            check("lock_ack", ack_o, 64'b01);
            check("lock_gap", edges - last, (acks == 1) ? 3 + WC : 2 + WC);
            last = edges;
            if (acks == 2) lock_i = 2'b00;
         end
      end
      check("lock_acks", acks, 3);
      exp_ptr = 1'b0;
      rand_inputs();
      txn(2'b11, 0);
`endif

      @(posedge clock); #1;
      check("ack_cleared", ack_o, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
